pc_unit: RTL and testbench

- Parametrised program-counter unit for the RV32I core; successor to the plain enable-gated PC register.
- Generates the sequential PC (+4), applies branch/jump redirects and holds the PC under stall.
- Buffers a redirect that arrives during a stall so it is never lost.
- Counts PC advances for performance monitoring; sits between the branch/jump logic and instruction-memory fetch.

---
 rtl/pc_unit.sv | 118 +++++++++++
 tb/tb_pc_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequential +4, branch/jump redirect, stall hold with a one-deep redirect buffer, advance counter.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 'h0000_0010,
    parameter int                CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             redirect_is_jalr,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             pc_valid,
    output logic             redirect_pending,
    output logic             misaligned,
    output logic [CNT_W-1:0] advance_count
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] pend_buf;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] apply_tgt;
    logic [XLEN-1:0] apply_pc;
    logic            apply_mis;

    assign pc_plus4 = pc_out + XLEN'(4);

    always_comb begin
        tgt = redirect_target;
        if (redirect_is_jalr) begin
            tgt[0] = 1'b0;
        end
`ifndef PC_MISALIGN_TRAP_EN
        tgt[1:0] = 2'b00;
`endif
    end

    // A fresh redirect arriving on the release cycle beats the buffered one.
    assign apply_tgt = (state == HOLD && !redirect_valid) ? pend_buf : tgt;

`ifdef PC_MISALIGN_TRAP_EN
    logic mis_q;
    assign apply_mis  = (apply_tgt[1:0] != 2'b00);
    assign misaligned = mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= 1'b0;
            if ((state == RUN && enable && redirect_valid) || (state == HOLD && enable)) begin
                mis_q <= apply_mis;
            end
        end
    end
`else
    assign apply_mis  = 1'b0;
    assign misaligned = 1'b0;
`endif

    assign apply_pc = apply_mis ? TRAP_VECTOR : apply_tgt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= BOOT;
            pc_out           <= RESET_VECTOR;
            pc_valid         <= 1'b0;
            redirect_pending <= 1'b0;
            pend_buf         <= '0;
            advance_count    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    pc_valid <= 1'b1;
                    if (redirect_valid) begin
                        pend_buf         <= tgt;
                        redirect_pending <= 1'b1;
                        state            <= HOLD;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (enable) begin
                        pc_out        <= redirect_valid ? apply_pc : pc_plus4;
                        advance_count <= advance_count + CNT_W'(1);
                    end else if (redirect_valid) begin
                        pend_buf         <= tgt;
                        redirect_pending <= 1'b1;
                        state            <= HOLD;
                    end
                end
                HOLD: begin
                    if (enable) begin
                        pc_out           <= apply_pc;
                        redirect_pending <= 1'b0;
                        advance_count    <= advance_count + CNT_W'(1);
                        state            <= RUN;
                    end else if (redirect_valid) begin
                        pend_buf <= tgt;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed steps push expected outputs; a negedge monitor pops and compares.
module tb_pc_unit;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam logic [31:0] TRAP = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        redirect_is_jalr = 1'b0;
    logic [31:0] pc_out, pc_plus4, advance_count;
    logic        pc_valid, redirect_pending, misaligned;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        pend;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    pc_unit dut (
        .clk(clk), .reset(reset), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .redirect_is_jalr(redirect_is_jalr),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
        .redirect_pending(redirect_pending), .misaligned(misaligned),
        .advance_count(advance_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs settle after posedge, sampled on the following negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.vld});
                chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
                chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                chk("advance_count", advance_count, e.cnt);
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic rv, input logic [31:0] t,
                        input logic j, input logic [31:0] epc, input logic ev, input logic ep,
                        input logic em, input logic [31:0] ec);
        exp_t e;
        reset = r; enable = en; redirect_valid = rv; redirect_target = t; redirect_is_jalr = j;
        @(posedge clk);
        e.pc = epc; e.vld = ev; e.pend = ep; e.mis = em; e.cnt = ec;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        //    rst en rv target        jalr exp_pc                              vld pend mis             cnt
        step(1, 0, 0, 32'h0,        0, 32'h0,                               0, 0, 0,                32'd0);
        step(0, 1, 0, 32'h0,        0, 32'h0,                               1, 0, 0,                32'd0);
        step(0, 1, 0, 32'h0,        0, 32'h4,                               1, 0, 0,                32'd1);
        step(0, 1, 0, 32'h0,        0, 32'h8,                               1, 0, 0,                32'd2);
        step(0, 1, 1, 32'h100,      0, 32'h100,                             1, 0, 0,                32'd3);
        step(0, 1, 0, 32'h0,        0, 32'h104,                             1, 0, 0,                32'd4);
        // stall with a redirect, held three cycles
        step(0, 0, 1, 32'h200,      0, 32'h104,                             1, 1, 0,                32'd4);
        step(0, 0, 0, 32'h0,        0, 32'h104,                             1, 1, 0,                32'd4);
        step(0, 0, 0, 32'h0,        0, 32'h104,                             1, 1, 0,                32'd4);
        step(0, 1, 0, 32'h0,        0, 32'h200,                             1, 0, 0,                32'd5);
        step(0, 1, 0, 32'h0,        0, 32'h204,                             1, 0, 0,                32'd6);
        // fresh redirect on release beats the buffer
        step(0, 0, 1, 32'h200,      0, 32'h204,                             1, 1, 0,                32'd6);
        step(0, 1, 1, 32'h300,      0, 32'h300,                             1, 0, 0,                32'd7);
        // JALR bit0 clearing, then a misaligned JALR target
        step(0, 1, 1, 32'h1235,     1, 32'h1234,                            1, 0, 0,                32'd8);
        step(0, 1, 1, 32'h1236,     1, FEAT ? TRAP : 32'h1234,              1, 0, FEAT,             32'd9);
        step(0, 1, 0, 32'h0,        0, FEAT ? TRAP + 32'd4 : 32'h1238,      1, 0, 0,                32'd10);
        // misaligned buffered redirect checked on release
        step(0, 0, 1, 32'h402,      0, FEAT ? TRAP + 32'd4 : 32'h1238,      1, 1, 0,                32'd10);
        step(0, 1, 0, 32'h0,        0, FEAT ? TRAP : 32'h400,               1, 0, FEAT,             32'd11);
        // latest buffered redirect wins
        step(0, 0, 1, 32'h500,      0, FEAT ? TRAP : 32'h400,               1, 1, 0,                32'd11);
        step(0, 0, 1, 32'h600,      0, FEAT ? TRAP : 32'h400,               1, 1, 0,                32'd11);
        step(0, 1, 0, 32'h0,        0, 32'h600,                             1, 0, 0,                32'd12);
        // wrap at the top of the address space
        step(0, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC,                      1, 0, 0,                32'd13);
        step(0, 1, 0, 32'h0,        0, 32'h0,                               1, 0, 0,                32'd14);
        // reset while a redirect is pending
        step(0, 0, 1, 32'h700,      0, 32'h0,                               1, 1, 0,                32'd14);
        step(1, 1, 0, 32'h0,        0, 32'h0,                               0, 0, 0,                32'd0);
        // redirect during BOOT is buffered, pc stays at reset vector
        step(0, 1, 1, 32'h800,      0, 32'h0,                               1, 1, 0,                32'd0);
        step(0, 1, 0, 32'h0,        0, 32'h800,                             1, 0, 0,                32'd1);
        step(0, 0, 0, 32'h0,        0, 32'h800,                             1, 0, 0,                32'd1);
        step(0, 1, 0, 32'h0,        0, 32'h804,                             1, 0, 0,                32'd2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
